// File: rtl/inst_issuer_pkg.sv
// Shared instruction definitions used by the issuer and its neighbours.
package inst_issuer_pkg;

    // Processing-element instruction
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] dst;
        logic [7:0] imm;
    } pe_inst_t;

    // Buffer-move instruction
    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] addr;
    } buf_inst_t;

    // Host-loaded instruction word: selector plus both sub-instructions
    typedef struct packed {
        logic      is_buf;
        pe_inst_t  pe_i;
        buf_inst_t buf_i;
    } instruction_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_issuer_fifo.sv
// inst_fifo: instruction storage with wrapping pointers and occupancy level.
// i_clear empties the queue; a push in the same cycle lands as the only entry.
module inst_fifo
    import inst_issuer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  instruction_t             i_wdata,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output instruction_t             o_head,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    instruction_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          w_push, w_pop;
    logic [AW-1:0] w_wr_idx;

    // Never overflow or underflow, whatever the caller asks for
    assign w_push   = i_push && (r_level != LW'(DEPTH));
    assign w_pop    = i_pop  && (r_level != '0) && !i_clear;
    assign w_wr_idx = i_clear ? '0 : r_wr_ptr;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= i_wdata;
    end

    // Pointer and level bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? AW'(1) : '0;
            r_level  <= w_push ? LW'(1) : '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/inst_issuer.sv
// inst_issuer: queues host instructions and presents them one at a time to
// the controller, with flush, protocol-error detection and optional stats.
// Define INST_ISSUER_STATS_EN to enable the saturating issued_count counter.
module inst_issuer
    import inst_issuer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  instruction_t           in_inst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output instruction_t           inst,
    output logic                   inst_valid,
    input  logic                   inst_exec_begins,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   protocol_err,
    output logic [15:0]            issued_count
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, FLUSH} state_t;

    state_t r_state, w_next;
    logic   r_err;
    logic   w_push, w_pop, w_clear, w_has, w_err, w_nonempty_next;

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_inst),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .o_head  (inst),
        .o_level (fifo_level)
    );

    // Ready ignores any same-cycle pop so the host sees a registered-only path
    assign in_ready   = (fifo_level < LW'(DEPTH)) && (r_state != FLUSH);
    assign w_push     = in_valid && in_ready;
    assign w_has      = (fifo_level != '0);
    assign w_pop      = (r_state == PRESENT) && inst_exec_begins && w_has;
    assign w_err      = inst_exec_begins && ((r_state == IDLE) || !w_has);
    assign inst_valid = (r_state == PRESENT);
    assign busy       = (r_state != IDLE);
    assign protocol_err = r_err;

    // Queue still holds something after this edge's push/pop
    assign w_nonempty_next = w_push || (w_pop ? (fifo_level > LW'(1)) : w_has);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and FIFO clear control
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = flush;
                if (w_push || (w_has && !flush)) w_next = PRESENT;
            end
            PRESENT: begin
                if (flush)                w_next = FLUSH;
                else if (w_nonempty_next) w_next = PRESENT;
                else                      w_next = IDLE;
            end
            FLUSH: begin
                w_clear = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Sticky protocol error: exec pulse with nothing outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_err <= 1'b0;
        else if (w_err) r_err <= 1'b1;
    end

`ifdef INST_ISSUER_STATS_EN
    logic [15:0] r_issued;
    logic        w_ack;

    // A head acknowledged in PRESENT or in the flush cycle counts as issued
    assign w_ack = inst_exec_begins && w_has && ((r_state == PRESENT) || (r_state == FLUSH));

    // Saturating count of acknowledged instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_issued <= '0;
        else if (w_ack) r_issued <= sat_inc16(r_issued);
    end

    assign issued_count = r_issued;
`else
    assign issued_count = '0;
`endif

endmodule

// File: tb/tb_inst_issuer.sv
// Directed + short random bench for inst_issuer with a queue scoreboard.
module tb_inst_issuer;
    import inst_issuer_pkg::*;

    localparam int DEPTH = 8;
    localparam int IW    = $bits(instruction_t);
`ifdef INST_ISSUER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk, rst;
    instruction_t in_inst, inst;
    logic         in_valid, in_ready, flush, inst_valid, inst_exec_begins;
    logic [$clog2(DEPTH):0] fifo_level;
    logic         busy, protocol_err;
    logic [15:0]  issued_count;

    inst_issuer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_inst          (in_inst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .flush            (flush),
        .inst             (inst),
        .inst_valid       (inst_valid),
        .inst_exec_begins (inst_exec_begins),
        .fifo_level       (fifo_level),
        .busy             (busy),
        .protocol_err     (protocol_err),
        .issued_count     (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 present, 2 flush
    instruction_t q[$];
    int           m_state;
    int           m_cnt;
    bit           m_err;

    function automatic instruction_t mk(input int n);
        logic [IW-1:0] b;
        b = IW'(n * 32'h0123_4567 + 32'h9A5);
        return instruction_t'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post_checks();
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("inst_valid", 64'(inst_valid), 64'(m_state == 1));
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("protocol_err", 64'(protocol_err), 64'(m_err));
        chk("issued_count", 64'(issued_count), STATS ? 64'(m_cnt) : 64'd0);
        if (m_state == 1 && q.size() > 0) chk("inst_head", 64'(inst), 64'(q[0]));
    endtask

    task automatic ack();
        if (m_cnt < 16'hFFFF) m_cnt++;
    endtask

    // One clock: check ready, update model with this cycle's inputs, then
    // step the DUT and compare its post-edge state
    task automatic tick();
        bit rdy, push;
        rdy  = (q.size() < DEPTH) && (m_state != 2);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        push = in_valid && rdy;
        if (m_state == 1 && inst_exec_begins && q.size() > 0)
            chk("inst_at_exec", 64'(inst), 64'(q[0]));
        case (m_state)
            0: begin
                if (flush) q.delete();
                if (inst_exec_begins) m_err = 1'b1;
                if (push) q.push_back(in_inst);
                m_state = (q.size() > 0) ? 1 : 0;
            end
            1: begin
                if (inst_exec_begins) begin
                    if (q.size() > 0) begin q.delete(0); ack(); end
                    else m_err = 1'b1;
                end
                if (push) q.push_back(in_inst);
                m_state = flush ? 2 : ((q.size() > 0) ? 1 : 0);
            end
            default: begin
                if (inst_exec_begins) begin
                    if (q.size() > 0) ack();
                    else m_err = 1'b1;
                end
                q.delete();
                m_state = 0;
            end
        endcase
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; inst_exec_begins = 1'b0;
        post_checks();
    endtask

    task automatic push(input int n);
        in_valid = 1'b1; in_inst = mk(n);
        tick();
    endtask

    // Assert reset between edges and check outputs fall before the next edge
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        q.delete(); m_state = 0; m_cnt = 0; m_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        post_checks();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; inst_exec_begins = 1'b0;
        in_inst = mk(0);
        q.delete(); m_state = 0; m_cnt = 0; m_err = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        post_checks();
        rst = 1'b0;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single instruction: visible next cycle, gone after exec pulse
        push(1);
        chk("single_valid", 64'(inst_valid), 64'd1);
        inst_exec_begins = 1'b1; tick();
        chk("single_idle", 64'(busy), 64'd0);
        tick();

        // Three back-to-back instructions from a clean count
        mid_reset();
        push(2); push(3); push(4);
        for (int i = 0; i < 3; i++) begin
            inst_exec_begins = 1'b1; tick();
        end
        chk("abc_count", 64'(issued_count), STATS ? 64'd3 : 64'd0);
        tick();

        // Fill, then a push held across a pop cycle is taken only afterwards
        for (int i = 0; i < DEPTH; i++) push(10 + i);
        chk("full_level", 64'(fifo_level), 64'(DEPTH));
        chk("full_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_inst = mk(99); inst_exec_begins = 1'b1; tick();
        chk("held_not_taken", 64'(fifo_level), 64'(DEPTH - 1));
        push(99);
        chk("held_taken", 64'(fifo_level), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            inst_exec_begins = 1'b1; tick();
        end

        // Flush with exec in the flush cycle: head counts as issued
        push(20); push(21);
        flush = 1'b1; tick();
        chk("flush_gap", 64'(inst_valid), 64'd0);
        inst_exec_begins = 1'b1; tick();
        chk("flush_level", 64'(fifo_level), 64'd0);

        // Flush without exec: count unchanged
        push(22); push(23);
        flush = 1'b1; tick();
        tick();

        // Exec pulse while idle sets a sticky error
        inst_exec_begins = 1'b1; tick();
        tick(); tick();
        chk("err_sticky", 64'(protocol_err), 64'd1);
        mid_reset();

        // Short random traffic to exercise pointer wrap
        for (int k = 0; k < 60; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_inst  = mk(100 + k);
            inst_exec_begins = (m_state == 1) && ($urandom_range(0, 2) != 0);
            tick();
        end
        for (int k = 0; k < 2 * DEPTH && m_state == 1; k++) begin
            inst_exec_begins = 1'b1; tick();
        end

        // Reset while presenting
        push(200); push(201);
        mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_inst  in  instruction_t  instruction from host loader.
- in_valid  in  1  in_inst valid.
- in_ready  out  1  FIFO can accept.
- flush  in  1  single-cycle request to discard all queued instructions.
- inst  out  instruction_t  instruction presented to controller.
- inst_valid  out  1  inst valid.
- inst_exec_begins  in  1  controller pulse: presented instruction started.
- fifo_level  out  $clog2(DEPTH)+1  occupied entries.
- busy  out  1  state != IDLE.
- protocol_err  out  1  sticky: inst_exec_begins seen with no instruction outstanding.
- issued_count  out  16  instructions acknowledged (see REQ-016).

Function
REQ-003 SHALL accept a push when in_valid && in_ready at a rising edge; in_ready = (fifo_level < DEPTH) && state != FLUSH, independent of same-cycle pop.
REQ-004 SHALL drive inst from the FIFO head; inst SHALL stay stable while inst_valid=1.
REQ-005 SHALL implement states IDLE, PRESENT, FLUSH; inst_valid=1 only in PRESENT.
REQ-006 IDLE->PRESENT on the edge where fifo_level becomes nonzero; first pushed instruction visible on inst one cycle after acceptance.
REQ-007 In PRESENT, inst_exec_begins=1 SHALL pop the head; remain PRESENT if entries remain (next instruction presented the following cycle, back-to-back), else go IDLE.
REQ-008 Simultaneous push and pop SHALL leave fifo_level unchanged; push into empty FIFO with no pop -> level 1.
REQ-009 inst_valid SHALL stay asserted during the cycle inst_exec_begins is high; the controller ignores it while executing.
REQ-010 flush in PRESENT SHALL go FLUSH: inst_valid=0 for exactly one cycle; if inst_exec_begins=1 in that cycle, the head counts as issued; then all entries discard, fifo_level=0, -> IDLE.
REQ-011 flush in IDLE SHALL discard all entries immediately (level 0 next cycle); flush in FLUSH is ignored.
REQ-012 inst_exec_begins in IDLE, or in PRESENT/FLUSH with no entry, SHALL set protocol_err until reset; no pointer changes.
REQ-013 Pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or underflow.

Reset
REQ-014 rst SHALL asynchronously force: state IDLE, pointers 0, fifo_level 0, inst_valid 0, protocol_err 0, issued_count 0; in_ready 1 after release.
REQ-015 Reset mid-PRESENT SHALL drop inst_valid immediately; queued instructions are lost; FIFO storage contents need not reset.

Configuration
REQ-016 Macro INST_ISSUER_STATS_EN defined: issued_count increments (saturating at 16'hFFFF) on each acknowledged pop, including REQ-010. Undefined: issued_count tied to 0, no counter logic.

Structure
REQ-017 instruction_t, pe_inst_t, buf_inst_t SHALL come from the shared defines; issuer state enum and DEPTH-derived widths stay local.
REQ-018 SHALL instantiate one sub-module inst_fifo (storage, pointers, level); FSM, flush, error, stats logic in inst_issuer.

Verification
REQ-019 Bench SHALL cover:
- Push A into empty FIFO -> inst=A, inst_valid=1 next cycle; exec_begins pulse 1 cycle later -> inst_valid=0, busy=0.
- Push A,B,C; controller model pulses exec_begins per instruction -> A,B,C presented in order, no gap after each pulse; issued_count=3 with STATS_EN.
- Fill DEPTH=8 -> in_ready=0, fifo_level=8; push held during pop cycle -> not accepted until following cycle.
- flush while presenting A, exec_begins in FLUSH cycle -> issued_count+1, fifo_level=0, IDLE; without exec_begins -> count unchanged.
- exec_begins pulse while IDLE -> protocol_err=1 and stays 1; rst -> 0.
- rst asserted mid-PRESENT between clock edges -> inst_valid=0 before next edge, fifo_level=0.
